// File: rtl/pattern_generator_param.sv
// Video test-pattern generator: one pixel per clock, LINES x LINE_LEN frame, started by f_sync & sync.
// Latency: sync sampled at edge T gives the first pixel (valid, sol) in the cycle after T.
// Backpressure: none; the pixel sink must accept one pixel per clock while valid is high.
//
// Ports: clk, rst_n (asynchronous, asserted HIGH despite the name), f_sync/sync (frame/line start),
//        mode/const_val/cell_sel/inv/delta_x/delta_y (pattern config, latched at frame start),
//        cnt/valid/sol/eol/sof/eof (pixel stream), line_idx, busy, err (mid-line sync pulse).
module pattern_generator_param #(
    parameter int DATA_W   = 12,
    parameter int LINE_LEN = 1290,
    parameter int LINES    = 24,
    parameter int LIDX_W   = (LINES > 1) ? $clog2(LINES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_sync,
    input  logic              sync,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] const_val,
    input  logic [1:0]        cell_sel,
    input  logic              inv,
    input  logic [DATA_W-1:0] delta_x,
    input  logic [DATA_W-1:0] delta_y,
    output logic [DATA_W-1:0] cnt,
    output logic              valid,
    output logic              sol,
    output logic              eol,
    output logic              sof,
    output logic              eof,
    output logic [LIDX_W-1:0] line_idx,
    output logic              busy,
    output logic              err
);

    localparam int XW = $clog2(LINE_LEN);
    localparam logic [XW-1:0]     X_LAST    = XW'(LINE_LEN - 1);
    localparam logic [LIDX_W-1:0] Y_LAST    = LIDX_W'(LINES - 1);
    localparam logic [15:0]       LFSR_SEED = 16'hACE1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LINE = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [2:0] MODE_GRAY  = 3'd1;
    localparam logic [2:0] MODE_CONST = 3'd2;
    localparam logic [2:0] MODE_CHECK = 3'd3;
    localparam logic [2:0] MODE_RAMP  = 3'd4;
    localparam logic [2:0] MODE_PRBS  = 3'd5;

    typedef struct packed {
        logic [2:0]        mode;
        logic [DATA_W-1:0] const_val;
        logic [1:0]        cell_sel;
        logic              inv;
        logic [DATA_W-1:0] dx;
        logic [DATA_W-1:0] dy;
    } cfg_t;

    logic [1:0]        state_q, st_n;
    logic [XW-1:0]     x_q, x_n;
    logic [LIDX_W-1:0] y_q, y_n;
    logic [DATA_W-1:0] row_q, row_n;     // ramp value at pixel 0 of the current line
    logic [DATA_W-1:0] ramp_q, ramp_n;   // ramp value of the pixel being presented
    logic [15:0]       lfsr_q, lfsr_n;   // PRBS value for the next valid pixel
    cfg_t              cfg_q, cfg_n, cfg_in;
    logic              err_n;
    logic              start_req, mode_ok, at_last, last_line;
    logic              do_frame, do_line, go_idle, restart;
    logic [15:0]       lfsr_step;
    logic [DATA_W-1:0] pix_n;
    logic              chk;
    logic              valid_n;

    assign cfg_in    = {mode, const_val, cell_sel, inv, delta_x, delta_y};
    assign start_req = f_sync & sync;
    assign mode_ok   = (mode != 3'd0) && (mode < 3'd6);   // 11x is reserved -> off
    assign at_last   = (x_q == X_LAST);
    assign last_line = (y_q == Y_LAST);
    assign lfsr_step = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_comb begin
        st_n     = state_q;
        x_n      = x_q;
        y_n      = y_q;
        row_n    = row_q;
        ramp_n   = ramp_q;
        cfg_n    = cfg_q;
        // The LFSR steps once per presented pixel and holds through gaps.
        lfsr_n   = (state_q == ST_LINE) ? lfsr_step : lfsr_q;
        err_n    = 1'b0;
        do_frame = 1'b0;
        do_line  = 1'b0;
        go_idle  = 1'b0;
        restart  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_req && mode_ok) do_frame = 1'b1;
            end
            ST_LINE: begin
                if (!at_last) begin
                    if (sync) begin
                        // Truncated line: no eol/eof, the new line starts next cycle.
                        err_n = 1'b1;
                        if (f_sync)         restart = 1'b1;
                        else if (last_line) go_idle = 1'b1;
                        else                do_line = 1'b1;
                    end else begin
                        x_n    = x_q + XW'(1);
                        ramp_n = ramp_q + cfg_q.dx;
                    end
                end else begin
                    // Line completed; a sync on this edge opens the next line directly.
                    if (start_req)      restart = 1'b1;
                    else if (last_line) go_idle = 1'b1;
                    else if (sync)      do_line = 1'b1;
                    else                st_n    = ST_GAP;
                end
            end
            ST_GAP: begin
                if (start_req) restart = 1'b1;
                else if (sync) do_line = 1'b1;
            end
            default: go_idle = 1'b1;
        endcase

        if (restart) begin
            if (mode_ok) do_frame = 1'b1;
            else         go_idle  = 1'b1;
        end

        if (do_frame) begin
            st_n   = ST_LINE;
            cfg_n  = cfg_in;
            x_n    = '0;
            y_n    = '0;
            row_n  = '0;
            ramp_n = '0;
            lfsr_n = LFSR_SEED;
        end else if (do_line) begin
            st_n   = ST_LINE;
            x_n    = '0;
            y_n    = y_q + LIDX_W'(1);
            row_n  = row_q + cfg_q.dy;
            ramp_n = row_q + cfg_q.dy;
        end else if (go_idle) begin
            st_n = ST_IDLE;
        end
    end

    // Pixel value for the coordinates that will be presented after this edge.
    always_comb begin
        chk   = 1'((32'(x_n) >> cfg_n.cell_sel) ^ (32'(y_n) >> cfg_n.cell_sel)) ^ cfg_n.inv;
        pix_n = '0;
        case (cfg_n.mode)
            MODE_GRAY:  pix_n = DATA_W'(x_n ^ (x_n >> 1));
            MODE_CONST: pix_n = cfg_n.const_val;
            MODE_CHECK: pix_n = {DATA_W{chk}};
            MODE_RAMP:  pix_n = ramp_n;
            MODE_PRBS:  pix_n = DATA_W'(lfsr_n);
            default:    pix_n = '0;
        endcase
    end

    assign valid_n = (st_n == ST_LINE);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            row_q   <= '0;
            ramp_q  <= '0;
            lfsr_q  <= LFSR_SEED;
            cfg_q   <= '0;
            cnt     <= '0;
            sol     <= 1'b0;
            eol     <= 1'b0;
            sof     <= 1'b0;
            eof     <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= st_n;
            x_q     <= x_n;
            y_q     <= y_n;
            row_q   <= row_n;
            ramp_q  <= ramp_n;
            lfsr_q  <= lfsr_n;
            cfg_q   <= cfg_n;
            cnt     <= valid_n ? pix_n : '0;
            sol     <= valid_n && (x_n == '0);
            eol     <= valid_n && (x_n == X_LAST);
            sof     <= valid_n && (x_n == '0) && (y_n == '0);
            eof     <= valid_n && (x_n == X_LAST) && (y_n == Y_LAST);
            err     <= err_n;
        end
    end

    assign valid    = (state_q == ST_LINE);
    assign busy     = (state_q != ST_IDLE);
    assign line_idx = y_q;

endmodule

// File: tb/tb_pattern_generator_param.sv
module tb_pattern_generator_param;
    localparam int DW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, f_sync, sync, inv;
    logic [2:0]    mode;
    logic [DW-1:0] const_val, delta_x, delta_y;
    logic [1:0]    cell_sel;

    logic [DW-1:0] d_cnt;
    logic          d_valid, d_sol, d_eol, d_sof, d_eof, d_busy, d_err;
    logic [4:0]    d_line;
    logic [DW-1:0] s_cnt;
    logic          s_valid, s_sol, s_eol, s_sof, s_eof, s_busy, s_err;
    logic [1:0]    s_line;

    pattern_generator_param u_dut (
        .clk(clk), .rst_n(rst_n), .f_sync(f_sync), .sync(sync), .mode(mode),
        .const_val(const_val), .cell_sel(cell_sel), .inv(inv),
        .delta_x(delta_x), .delta_y(delta_y),
        .cnt(d_cnt), .valid(d_valid), .sol(d_sol), .eol(d_eol), .sof(d_sof), .eof(d_eof),
        .line_idx(d_line), .busy(d_busy), .err(d_err)
    );

    pattern_generator_param #(.DATA_W(12), .LINE_LEN(8), .LINES(4)) u_chk (
        .clk(clk), .rst_n(rst_n), .f_sync(f_sync), .sync(sync), .mode(mode),
        .const_val(const_val), .cell_sel(cell_sel), .inv(inv),
        .delta_x(delta_x), .delta_y(delta_y),
        .cnt(s_cnt), .valid(s_valid), .sol(s_sol), .eol(s_eol), .sof(s_sof), .eof(s_eof),
        .line_idx(s_line), .busy(s_busy), .err(s_err)
    );

    typedef struct {
        logic [DW-1:0] cnt;
        logic          sol, eol, sof, eof;
        logic [4:0]    line;
    } exp_t;

    exp_t q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n  = 1'b1;
        f_sync = 1'b0;
        sync   = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({d_cnt, d_valid, d_sol, d_eol, d_sof, d_eof, d_busy, d_err, d_line} !== '0) begin
            tests_failed++;
            $display("FAIL reset_default: cnt=%h v=%b busy=%b line=%0d, want all 0", d_cnt, d_valid, d_busy, d_line);
        end
        tests_run++;
        if ({s_cnt, s_valid, s_sol, s_eol, s_sof, s_eof, s_busy, s_err, s_line} !== '0) begin
            tests_failed++;
            $display("FAIL reset_small: cnt=%h v=%b busy=%b line=%0d, want all 0", s_cnt, s_valid, s_busy, s_line);
        end
        rst_n = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (d_busy !== 1'b0 || d_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: busy=%b valid=%b, want 0 0", d_busy, d_valid);
        end
    endtask

    task automatic test_mode_off;
        logic [2:0] m;
        for (int i = 0; i < 2; i++) begin
            reset_dut();
            m = (i == 0) ? 3'd0 : 3'd6;
            mode = m;
            f_sync = 1'b1; sync = 1'b1;
            tick();
            f_sync = 1'b0; sync = 1'b0;
            tick();
            tests_run++;
            if (d_busy !== 1'b0 || d_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL mode_off_%0d: busy=%b valid=%b, want 0 0", m, d_busy, d_valid);
            end
        end
    endtask

    task automatic test_gray;
        exp_t e;
        reset_dut();
        mode = 3'd1;
        q.delete();
        for (int x = 0; x < 1290; x++)
            q.push_back('{DW'(x ^ (x >> 1)), x == 0, x == 1289, x == 0, 1'b0, 5'd0});
        f_sync = 1'b1; sync = 1'b1;
        tick();
        f_sync = 1'b0; sync = 1'b0;
        for (int p = 0; p < 1290; p++) begin
            e = q.pop_front();
            tests_run++;
            if (d_valid !== 1'b1 || d_cnt !== e.cnt || d_sol !== e.sol || d_eol !== e.eol ||
                d_sof !== e.sof || d_eof !== e.eof || d_line !== e.line) begin
                tests_failed++;
                $display("FAIL gray_px%0d: v=%b cnt=%h sol=%b eol=%b sof=%b eof=%b line=%0d, want cnt=%h sol=%b eol=%b sof=%b eof=%b line=%0d",
                         p, d_valid, d_cnt, d_sol, d_eol, d_sof, d_eof, d_line, e.cnt, e.sol, e.eol, e.sof, e.eof, e.line);
            end
            tick();
        end
        tests_run++;
        if (d_valid !== 1'b0 || d_busy !== 1'b1 || d_cnt !== '0 || d_eol !== 1'b0) begin
            tests_failed++;
            $display("FAIL gray_gap: v=%b busy=%b cnt=%h eol=%b, want 0 1 000 0", d_valid, d_busy, d_cnt, d_eol);
        end
    endtask

    task automatic test_checker;
        exp_t e;
        logic c;
        reset_dut();
        mode = 3'd3; cell_sel = 2'd1; inv = 1'b0;
        q.delete();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++) begin
                c = 1'(((x >> 1) ^ (y >> 1)) & 1);
                q.push_back('{c ? 12'hFFF : 12'h000, x == 0, x == 7, x == 0 && y == 0, x == 7 && y == 3, 5'(y)});
            end
        for (int ln = 0; ln < 4; ln++) begin
            f_sync = (ln == 0); sync = 1'b1;
            tick();
            f_sync = 1'b0; sync = 1'b0;
            for (int p = 0; p < 8; p++) begin
                e = q.pop_front();
                tests_run++;
                if (s_valid !== 1'b1 || s_cnt !== e.cnt || s_sol !== e.sol || s_eol !== e.eol ||
                    s_sof !== e.sof || s_eof !== e.eof || s_line !== e.line[1:0]) begin
                    tests_failed++;
                    $display("FAIL checker_l%0d_px%0d: v=%b cnt=%h sol=%b eol=%b sof=%b eof=%b line=%0d, want cnt=%h sol=%b eol=%b sof=%b eof=%b",
                             ln, p, s_valid, s_cnt, s_sol, s_eol, s_sof, s_eof, s_line, e.cnt, e.sol, e.eol, e.sof, e.eof);
                end
                if (p < 7) tick();
            end
            tick();
            tests_run++;
            if (s_valid !== 1'b0 || s_busy !== (ln < 3) || s_eof !== 1'b0) begin
                tests_failed++;
                $display("FAIL checker_after_l%0d: v=%b busy=%b eof=%b, want 0 %b 0", ln, s_valid, s_busy, s_eof, ln < 3);
            end
        end
    endtask

    task automatic test_ramp;
        exp_t e;
        reset_dut();
        mode = 3'd4; delta_x = 12'd8; delta_y = 12'h50A;
        q.delete();
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 1290; x++)
                q.push_back('{DW'(y * 'h50A + x * 8), x == 0, x == 1289, x == 0 && y == 0, 1'b0, 5'(y)});
        for (int ln = 0; ln < 5; ln++) begin
            f_sync = (ln == 0); sync = 1'b1;
            tick();
            f_sync = 1'b0; sync = 1'b0;
            for (int p = 0; p < 1290; p++) begin
                e = q.pop_front();
                tests_run++;
                if (d_valid !== 1'b1 || d_cnt !== e.cnt || d_sol !== e.sol || d_eol !== e.eol ||
                    d_sof !== e.sof || d_eof !== e.eof || d_line !== e.line) begin
                    tests_failed++;
                    $display("FAIL ramp_l%0d_px%0d: v=%b cnt=%h sol=%b eol=%b line=%0d, want cnt=%h sol=%b eol=%b line=%0d",
                             ln, p, d_valid, d_cnt, d_sol, d_eol, d_line, e.cnt, e.sol, e.eol, e.line);
                end
                if (p < 1289) tick();
            end
            tick();
        end
    endtask

    task automatic test_prbs;
        exp_t e;
        logic [15:0] lfsr;
        int len;
        reset_dut();
        mode = 3'd5;
        q.delete();
        lfsr = 16'hACE1;
        for (int y = 0; y < 2; y++)
            for (int x = 0; x < 1290; x++) begin
                q.push_back('{lfsr[11:0], x == 0, x == 1289, x == 0 && y == 0, 1'b0, 5'(y)});
                lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            end
        lfsr = 16'hACE1;
        for (int x = 0; x < 3; x++) begin
            q.push_back('{lfsr[11:0], x == 0, 1'b0, x == 0, 1'b0, 5'd0});
            lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
        for (int ln = 0; ln < 3; ln++) begin
            f_sync = (ln != 1); sync = 1'b1;
            tick();
            f_sync = 1'b0; sync = 1'b0;
            len = (ln == 2) ? 3 : 1290;
            for (int p = 0; p < len; p++) begin
                e = q.pop_front();
                tests_run++;
                if (d_valid !== 1'b1 || d_cnt !== e.cnt || d_sol !== e.sol || d_eol !== e.eol ||
                    d_sof !== e.sof || d_line !== e.line) begin
                    tests_failed++;
                    $display("FAIL prbs_seg%0d_px%0d: v=%b cnt=%h sol=%b eol=%b sof=%b line=%0d, want cnt=%h sol=%b eol=%b sof=%b line=%0d",
                             ln, p, d_valid, d_cnt, d_sol, d_eol, d_sof, d_line, e.cnt, e.sol, e.eol, e.sof, e.line);
                end
                if (p < len - 1) tick();
            end
            tick();
        end
    endtask

    task automatic test_sync_err;
        reset_dut();
        mode = 3'd2; const_val = 12'h5A5;
        for (int ln = 0; ln < 2; ln++) begin
            f_sync = (ln == 0); sync = 1'b1;
            tick();
            f_sync = 1'b0; sync = 1'b0;
            if (ln == 1) const_val = 12'h123;
            repeat (1290) tick();
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        repeat (5) tick();
        tests_run++;
        if (d_valid !== 1'b1 || d_cnt !== 12'h5A5 || d_err !== 1'b0 || d_eol !== 1'b0 || d_line !== 5'd2) begin
            tests_failed++;
            $display("FAIL sync_err_pre: v=%b cnt=%h err=%b eol=%b line=%0d, want 1 5a5 0 0 2", d_valid, d_cnt, d_err, d_eol, d_line);
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tests_run++;
        if (d_err !== 1'b1 || d_sol !== 1'b1 || d_line !== 5'd3 || d_cnt !== 12'h5A5 ||
            d_valid !== 1'b1 || d_eol !== 1'b0 || d_sof !== 1'b0) begin
            tests_failed++;
            $display("FAIL sync_err_hit: err=%b sol=%b line=%0d cnt=%h v=%b eol=%b sof=%b, want 1 1 3 5a5 1 0 0",
                     d_err, d_sol, d_line, d_cnt, d_valid, d_eol, d_sof);
        end
        tick();
        tests_run++;
        if (d_err !== 1'b0 || d_sol !== 1'b0 || d_line !== 5'd3 || d_cnt !== 12'h5A5) begin
            tests_failed++;
            $display("FAIL sync_err_post: err=%b sol=%b line=%0d cnt=%h, want 0 0 3 5a5", d_err, d_sol, d_line, d_cnt);
        end
    endtask

    task automatic test_last_trunc;
        reset_dut();
        mode = 3'd2; const_val = 12'h3C3;
        for (int ln = 0; ln < 3; ln++) begin
            f_sync = (ln == 0); sync = 1'b1;
            tick();
            f_sync = 1'b0; sync = 1'b0;
            repeat (8) tick();
        end
        sync = 1'b1;
        tick();
        sync = 1'b0;
        repeat (2) tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tests_run++;
        if (s_err !== 1'b1 || s_valid !== 1'b0 || s_busy !== 1'b0 || s_eof !== 1'b0 || s_cnt !== '0) begin
            tests_failed++;
            $display("FAIL last_trunc: err=%b v=%b busy=%b eof=%b cnt=%h, want 1 0 0 0 000", s_err, s_valid, s_busy, s_eof, s_cnt);
        end
        tick();
        tests_run++;
        if (s_err !== 1'b0 || s_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL last_trunc_post: err=%b busy=%b, want 0 0", s_err, s_busy);
        end
    endtask

    task automatic test_reset_mid;
        reset_dut();
        mode = 3'd1;
        f_sync = 1'b1; sync = 1'b1;
        tick();
        f_sync = 1'b0; sync = 1'b0;
        repeat (10) tick();
        tests_run++;
        if (d_valid !== 1'b1 || d_cnt !== 12'h00F) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: v=%b cnt=%h, want 1 00f", d_valid, d_cnt);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (d_cnt !== '0 || d_valid !== 1'b0 || d_busy !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_async: cnt=%h v=%b busy=%b sv=%b sbusy=%b, want all 0", d_cnt, d_valid, d_busy, s_valid, s_busy);
        end
        tick();
        rst_n = 1'b0;
        tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick();
        tests_run++;
        if (d_valid !== 1'b0 || d_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_sync_only: v=%b busy=%b, want 0 0", d_valid, d_busy);
        end
        f_sync = 1'b1; sync = 1'b1;
        tick();
        f_sync = 1'b0; sync = 1'b0;
        tests_run++;
        if (d_valid !== 1'b1 || d_sol !== 1'b1 || d_sof !== 1'b1 || d_line !== 5'd0 || d_cnt !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_mid_restart: v=%b sol=%b sof=%b line=%0d cnt=%h, want 1 1 1 0 000", d_valid, d_sol, d_sof, d_line, d_cnt);
        end
        tick();
        tests_run++;
        if (d_cnt !== 12'h001 || d_sof !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_px1: cnt=%h sof=%b, want 001 0", d_cnt, d_sof);
        end
    endtask

    initial begin
        rst_n = 1'b1; f_sync = 1'b0; sync = 1'b0; mode = 3'd0;
        const_val = '0; cell_sel = 2'd0; inv = 1'b0; delta_x = '0; delta_y = '0;
        test_reset();
        test_mode_off();
        test_gray();
        test_checker();
        test_ramp();
        test_prbs();
        test_sync_err();
        test_last_trunc();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
